// File: rtl/counter_checker_if.sv
// Observation bus between an up/down/load counter and counter_checker.
// The bus has no flow control: every rising edge of clk is one transaction,
// the checker samples all fields on every edge and never back-pressures.
// master = the side driving the counter signals, slave = the checker.
interface counter_checker_if #(
   parameter int WIDTH = 4
);
   logic             dut_enable;
   logic [1:0]       dut_mode;
   logic [WIDTH-1:0] dut_d;
   logic [WIDTH-1:0] dut_q;
   logic             dut_rco;
   logic             dut_load;

   modport master (
      output dut_enable, dut_mode, dut_d, dut_q, dut_rco, dut_load
   );

   modport slave (
      input dut_enable, dut_mode, dut_d, dut_q, dut_rco, dut_load
   );
endinterface

// File: rtl/counter_checker.sv
// counter_checker: shadow model of a 4-mode counter (+1, -1, -3, load D).
// Each edge it predicts the counter's next q/load/rco from the sampled
// controls, then compares the counter's outputs against that prediction one
// edge later. A q mismatch resyncs the model to the observed q, so a single
// fault produces a single error. Sticky fail plus saturating statistics.
// Optional build macro RCO_CHECK_EN: capture dut_rco on the falling edge and
// include it in the compare; without it mismatch[2] is always 0.
module counter_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   counter_checker_if.slave  mon,
   output logic [WIDTH-1:0]  exp_q,
   output logic              error,
   output logic [2:0]        mismatch,
   output logic              fail,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  rco_count
);

   logic             exp_load;
   logic             exp_rco;
   logic             cmp_valid;
   logic             mis_q;
   logic             mis_load;
   logic             mis_rco;
   logic [2:0]       cur_mis;
   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] nxt_q;
   logic             nxt_load;
   logic             nxt_rco;

`ifdef RCO_CHECK_EN
   logic rco_cap;

   // rco is a half-cycle pulse; grab it on the falling edge before it clears
   always_ff @(negedge clk) begin
      if (reset) rco_cap <= 1'b0;
      else       rco_cap <= mon.dut_rco;
   end

   assign mis_rco = cmp_valid && (rco_cap != exp_rco);
`else
   logic unused_rco;
   assign unused_rco = mon.dut_rco;
   assign mis_rco    = 1'b0;
`endif

   assign mis_q    = cmp_valid && (mon.dut_q != exp_q);
   assign mis_load = cmp_valid && (mon.dut_load != exp_load);
   assign cur_mis  = {mis_rco, mis_load, mis_q};

   // On a q mismatch the next prediction starts from what the counter shows
   assign base_q = mis_q ? mon.dut_q : exp_q;

   // Next-value prediction from the sampled controls and the (resynced) model q
   always_comb begin
      nxt_q    = '0;
      nxt_load = 1'b0;
      nxt_rco  = 1'b0;
      if (!mon.dut_enable) begin
         nxt_load = (mon.dut_mode == 2'd3);
      end else begin
         case (mon.dut_mode)
            2'd0: begin
               nxt_q   = base_q + WIDTH'(1);
               nxt_rco = &base_q;
            end
            2'd1: begin
               nxt_q   = base_q - WIDTH'(1);
               nxt_rco = (base_q == '0);
            end
            2'd2: begin
               nxt_q   = base_q - WIDTH'(3);
               nxt_rco = (base_q <= WIDTH'(2));
            end
            default: begin
               nxt_q    = mon.dut_d;
               nxt_load = 1'b1;
            end
         endcase
      end
   end

   // Model state, compare-valid and compare results, registered every edge
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q     <= '0;
         exp_load  <= 1'b0;
         exp_rco   <= 1'b0;
         cmp_valid <= 1'b0;
         error     <= 1'b0;
         mismatch  <= 3'b000;
      end else begin
         exp_q     <= nxt_q;
         exp_load  <= nxt_load;
         exp_rco   <= nxt_rco;
         cmp_valid <= 1'b1;
         error     <= |cur_mis;
         mismatch  <= cur_mis;
      end
   end

   // Sticky fail flag and saturating error / expected-rco statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         fail      <= 1'b0;
         err_count <= '0;
         rco_count <= '0;
      end else begin
         if (|cur_mis) fail <= 1'b1;
         if ((|cur_mis) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
         if (nxt_rco && (rco_count != '1))    rco_count <= rco_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a behavioural counter drives the observation bus
// (with optional injected faults) and a reference model of the checker,
// written with plain integer arithmetic, predicts every checker output.
module tb_counter_checker;
   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int MODV  = 1 << WIDTH;
   localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef RCO_CHECK_EN
   localparam bit RCO_ON = 1'b1;
`else
   localparam bit RCO_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   counter_checker_if #(.WIDTH(WIDTH)) mon ();

   logic [WIDTH-1:0] exp_q;
   logic             error;
   logic [2:0]       mismatch;
   logic             fail;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] rco_count;

   counter_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .mon       (mon),
      .exp_q     (exp_q),
      .error     (error),
      .mismatch  (mismatch),
      .fail      (fail),
      .err_count (err_count),
      .rco_count (rco_count)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [WIDTH-1:0] exp_queue[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
   endtask

   // Counter behaviour rules: next q, load and rco from current q and controls
   function automatic void count_rule(input int q, input int en, input int md, input int d,
                                      output int nq, output bit ld, output bit rc);
      nq = 0; ld = 1'b0; rc = 1'b0;
      if (en == 0) ld = (md == 3);
      else case (md)
         0:       begin nq = (q + 1) % MODV;        rc = (q == MODV - 1); end
         1:       begin nq = (q + MODV - 1) % MODV; rc = (q == 0);        end
         2:       begin nq = (q + MODV - 3) % MODV; rc = (q <= 2);        end
         default: begin nq = d % MODV;              ld = 1'b1;            end
      endcase
   endfunction

   // Reference model of the checker
   int m_q = 0, m_mis = 0, m_err_cnt = 0, m_rco_cnt = 0;
   bit m_load = 0, m_rco = 0, m_valid = 0, m_fail = 0, m_error = 0;
   // Behavioural counter and what the checker will observe on the next edge
   int cnt = 0, obs_q = 0;
   bit obs_load = 0, obs_rco = 0;

   // ---------------- driver ----------------
   // One clock: present controls, model the edge, check, drive counter outputs.
   // fq >= 0 forces the observed q to fq for one cycle.
   task automatic tick(input int en, input int md, input int d, input int fq,
                       input bit kill_load, input bit kill_rco, input bit rst);
      int base, mis, nq;
      bit ld, rc;
      reset          = rst;
      mon.dut_enable = (en != 0);
      mon.dut_mode   = 2'(md);
      mon.dut_d      = WIDTH'(d);
      @(posedge clk);
      #1;
      if (rst) begin
         m_q = 0; m_load = 0; m_rco = 0; m_valid = 0; m_error = 0;
         m_mis = 0; m_fail = 0; m_err_cnt = 0; m_rco_cnt = 0;
      end else begin
         mis = 0;
         if (m_valid) begin
            if (obs_q != m_q)                mis |= 1;
            if (obs_load != m_load)          mis |= 2;
            if (RCO_ON && (obs_rco != m_rco)) mis |= 4;
         end
         base = ((mis & 1) != 0) ? obs_q : m_q;
         count_rule(base, en, md, d, nq, ld, rc);
         m_q = nq; m_load = ld; m_rco = rc;
         m_valid = 1; m_mis = mis; m_error = (mis != 0);
         if (mis != 0) m_fail = 1;
         if (mis != 0 && m_err_cnt < MAXC) m_err_cnt++;
         if (rc && m_rco_cnt < MAXC) m_rco_cnt++;
      end
      exp_queue.push_back(WIDTH'(m_q));
      check("exp_q",     exp_q,     exp_queue.pop_front());
      check("error",     error,     m_error);
      check("mismatch",  mismatch,  m_mis);
      check("fail",      fail,      m_fail);
      check("err_count", err_count, m_err_cnt);
      check("rco_count", rco_count, m_rco_cnt);
      // behavioural counter responds to the same edge
      if (rst) begin
         cnt = 0; ld = 0; rc = 0;
      end else begin
         count_rule(cnt, en, md, d, nq, ld, rc);
         cnt = nq;
      end
      obs_q    = (fq >= 0) ? fq : cnt;
      obs_load = kill_load ? 1'b0 : ld;
      obs_rco  = kill_rco  ? 1'b0 : rc;
      mon.dut_q    = WIDTH'(obs_q);
      mon.dut_load = obs_load;
      mon.dut_rco  = obs_rco;
      @(negedge clk);
      #1;
      mon.dut_rco = 1'b0;
   endtask

   task automatic reset_run();
      repeat (2) tick(0, 0, 0, -1, 0, 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d;
      mon.dut_enable = 1'b0; mon.dut_mode = 2'd0; mon.dut_d = '0;
      mon.dut_q = '0; mon.dut_load = 1'b0; mon.dut_rco = 1'b0;

      reset_run();
      check("rst_exp_q", exp_q, 0);
      check("rst_err_count", err_count, 0);
      check("rst_mismatch", mismatch, 0);

      // count up 17 cycles from 0: wraps once
      repeat (17) tick(1, 0, 0, -1, 0, 0, 0);
      check("wrap_exp_q", exp_q, 1);
      check("wrap_rco_count", rco_count, 1);
      check("wrap_err_count", err_count, 0);
      check("wrap_fail", fail, 0);

      // -3 from 1 gives 14 with rco; rco suppressed on the bus
      reset_run();
      tick(1, 3, 1, -1, 0, 0, 0);
      tick(1, 2, 0, -1, 0, 1, 0);
      check("m2_exp_q", exp_q, 14);
      tick(1, 3, 0, -1, 0, 0, 0);
      check("m2_mismatch", mismatch, RCO_ON ? 3'b100 : 3'b000);
      check("m2_error", error, RCO_ON);

      // disabled load request: load expected, bus shows 0
      reset_run();
      tick(0, 3, 6, -1, 1, 0, 0);
      check("dis_exp_q", exp_q, 0);
      tick(0, 0, 0, -1, 0, 0, 0);
      check("dis_mismatch", mismatch, 3'b010);
      check("dis_fail", fail, 1);

      // single q glitch while loading 9: exactly one error
      reset_run();
      repeat (3) tick(1, 3, 9, -1, 0, 0, 0);
      tick(1, 3, 9, 5, 0, 0, 0);
      repeat (10) tick(1, 3, 9, -1, 0, 0, 0);
      check("glitch_err_count", err_count, 1);

      // 300 q faults saturate err_count, then reset clears everything
      reset_run();
      repeat (300) begin
         d = $urandom_range(0, MODV - 1);
         tick(1, 3, d, d ^ 1, 0, 0, 0);
      end
      tick(1, 3, 0, -1, 0, 0, 0);
      check("sat_err_count", err_count, MAXC);
      reset_run();
      check("sat_rst_err_count", err_count, 0);
      check("sat_rst_fail", fail, 0);
      tick(1, 0, 0, 7, 0, 0, 0);
      check("first_edge_error", error, 0);
      tick(1, 0, 0, -1, 0, 0, 0);
      check("second_edge_error", error, 1);
      check("second_edge_mismatch", mismatch, 3'b001);

      // randomized traffic with sporadic faults and mid-run resets
      repeat (400) begin
         tick(($urandom_range(0, 7) != 0) ? 1 : 0,
              $urandom_range(0, 3),
              $urandom_range(0, MODV - 1),
              ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, MODV - 1)) : -1,
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 63) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
